// File: rtl/vga_scanout.sv
// vga_scanout: 640x480 VGA timing generator. It scans a 160x120 3-bit framebuffer
// held in synchronous RAM and shows each framebuffer pixel as a 4x4 block.
// Ports: CLOCK_50/resetn (sync, active-low); rd_addr/rd_data to the framebuffer RAM;
// VGA_R/G/B, VGA_HS/VS, VGA_BLANK_N, VGA_SYNC_N and VGA_CLK to the DAC; frame_start pulse.
module vga_scanout #(
   parameter int H_VISIBLE   = 640,
   parameter int V_VISIBLE   = 480,
   parameter int SCALE_SHIFT = 2
) (
   input  logic        CLOCK_50,
   input  logic        resetn,
   output logic [14:0] rd_addr,
   input  logic [2:0]  rd_data,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic        VGA_CLK,
   output logic        frame_start
);

   // Porch and sync widths are fixed; only the visible extent is a parameter.
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] H_SS   = 10'(H_VISIBLE + 16);
   localparam logic [9:0] H_SE   = 10'(H_VISIBLE + 112);
   localparam logic [9:0] H_LAST = 10'(H_VISIBLE + 159);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] V_SS   = 10'(V_VISIBLE + 10);
   localparam logic [9:0] V_SE   = 10'(V_VISIBLE + 12);
   localparam logic [9:0] V_LAST = 10'(V_VISIBLE + 44);

   logic        pix_en;
   logic [9:0]  hcnt;
   logic [9:0]  vcnt;
   logic [9:0]  h_nxt;
   logic [9:0]  v_nxt;
   logic        h_end;
   logic        v_end;
   logic        vis_cur;
   logic        vis_nxt;
   logic        hs_cur;
   logic        vs_cur;
   logic [14:0] fb_x;
   logic [14:0] fb_y;
   logic [14:0] addr_nxt;

   assign h_end   = (hcnt == H_LAST);
   assign v_end   = (vcnt == V_LAST);
   assign vis_cur = (hcnt < H_VIS) && (vcnt < V_VIS);
   assign vis_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
   assign hs_cur  = (hcnt >= H_SS) && (hcnt < H_SE);
   assign vs_cur  = (vcnt >= V_SS) && (vcnt < V_SE);

   always_comb begin
      h_nxt = hcnt;
      v_nxt = vcnt;
      if (pix_en) begin
         if (h_end) begin
            h_nxt = '0;
            v_nxt = v_end ? '0 : vcnt + 10'd1;
         end else begin
            h_nxt = hcnt + 10'd1;
         end
      end
   end

   // The address follows the counters into their new value so the RAM has
   // the whole pixel period; the colour register then samples rd_data at the
   // end of that period, together with the sync and blank flags.
   assign fb_x     = 15'(h_nxt >> SCALE_SHIFT);
   assign fb_y     = 15'(v_nxt >> SCALE_SHIFT);
   assign addr_nxt = (fb_y << 7) + (fb_y << 5) + fb_x;

   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         pix_en      <= 1'b0;
         hcnt        <= '0;
         vcnt        <= '0;
         rd_addr     <= '0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         pix_en      <= ~pix_en;
         hcnt        <= h_nxt;
         vcnt        <= v_nxt;
         frame_start <= pix_en & h_end & v_end;
         if (pix_en) begin
            rd_addr     <= vis_nxt ? addr_nxt : '0;
            VGA_R       <= {8{vis_cur & rd_data[2]}};
            VGA_G       <= {8{vis_cur & rd_data[1]}};
            VGA_B       <= {8{vis_cur & rd_data[0]}};
            VGA_HS      <= ~hs_cur;
            VGA_VS      <= ~vs_cur;
            VGA_BLANK_N <= vis_cur;
         end
      end
   end

   assign VGA_SYNC_N = 1'b0;
   assign VGA_CLK    = pix_en;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: checks a full-size and a shrunken vga_scanout against a
// closed-form model of scan position versus clocks elapsed since reset.
module tb_vga_scanout;

   logic        clk = 1'b0;
   logic        resetn;
   logic        run = 1'b0;

   logic [2:0]  mem [19200];

   logic [14:0] d_addr, s_addr;
   logic [2:0]  d_rd, s_rd;
   logic [7:0]  d_r, d_g, d_b, s_r, s_g, s_b;
   logic        d_hs, d_vs, d_bl, d_sy, d_vc, d_fs;
   logic        s_hs, s_vs, s_bl, s_sy, s_vc, s_fs;

   int n_chk = 0;
   int n_pass = 0;
   int k = 0;
   bit rs;
   int d_f1, d_f2, d_r1, s_f1, s_f2, s_r1, fs_n, fs_k1;
   logic d_hs_p, s_vs_p;

   always #5 clk = ~clk;

   vga_scanout u_def (
      .CLOCK_50(clk), .resetn(resetn), .rd_addr(d_addr), .rd_data(d_rd),
      .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .VGA_HS(d_hs), .VGA_VS(d_vs),
      .VGA_BLANK_N(d_bl), .VGA_SYNC_N(d_sy), .VGA_CLK(d_vc),
      .frame_start(d_fs)
   );

   vga_scanout #(.H_VISIBLE(32), .V_VISIBLE(16), .SCALE_SHIFT(2)) u_sml (
      .CLOCK_50(clk), .resetn(resetn), .rd_addr(s_addr), .rd_data(s_rd),
      .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
      .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sy), .VGA_CLK(s_vc),
      .frame_start(s_fs)
   );

   // Synchronous framebuffer RAMs sharing one random image.
   always @(posedge clk) begin
      d_rd <= (d_addr < 15'd19200) ? mem[d_addr] : 3'd0;
      s_rd <= (s_addr < 15'd19200) ? mem[s_addr] : 3'd0;
   end

   task automatic check(input string tag, input logic [44:0] got,
                        input logic [44:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Outputs after k clock edges since reset release. The scan position
   // advances one pixel every two edges; outputs show the previous pixel.
   function automatic logic [44:0] model(int kk, int hv, int vv);
      int htot, ftot, p, q, h, v;
      logic [2:0]  c;
      logic        vis, hs, vs, bl, fs;
      logic [14:0] ra;
      logic [23:0] rgb;
      htot = hv + 160;
      ftot = htot * (vv + 45);
      p = (kk / 2) % ftot;
      h = p % htot;
      v = p / htot;
      ra = (h < hv && v < vv) ? 15'((v / 4) * 160 + h / 4) : 15'd0;
      rgb = '0;
      hs = 1'b1;
      vs = 1'b1;
      bl = 1'b0;
      if (kk >= 2) begin
         q = (kk / 2 - 1) % ftot;
         h = q % htot;
         v = q / htot;
         vis = (h < hv && v < vv);
         if (vis) begin
            c = mem[(v / 4) * 160 + h / 4];
            rgb = {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
         end
         hs = !(h >= hv + 16 && h < hv + 112);
         vs = !(v >= vv + 10 && v < vv + 12);
         bl = vis;
      end
      fs = (kk > 0) && (kk % 2 == 0) && ((kk / 2) % ftot == 0);
      return {ra, rgb, hs, vs, bl, 1'b0, 1'(kk % 2), fs};
   endfunction

   always @(posedge clk) begin
      if (run) begin
         rs = !resetn;
         #1;
         k = rs ? 0 : k + 1;
         check($sformatf("def k=%0d", k),
               {d_addr, d_r, d_g, d_b, d_hs, d_vs, d_bl, d_sy, d_vc, d_fs},
               model(k, 640, 480));
         check($sformatf("sml k=%0d", k),
               {s_addr, s_r, s_g, s_b, s_hs, s_vs, s_bl, s_sy, s_vc, s_fs},
               model(k, 32, 16));
         if (k == 8)    check("addr_h4v0", 45'(d_addr), 45'd1);
         if (k == 15)   check("addr_h7v0", 45'(d_addr), 45'd1);
         if (k == 16)   check("addr_h8v0", 45'(d_addr), 45'd2);
         if (k == 6400) check("addr_h0v4", 45'(d_addr), 45'd160);
         if (k == 5822) check("addr_sml_last", 45'(s_addr), 45'd487);
         if (k == 0) begin
            d_f1 = -1; d_f2 = -1; d_r1 = -1;
            s_f1 = -1; s_f2 = -1; s_r1 = -1;
            fs_n = 0;  fs_k1 = -1;
         end else begin
            if (!d_hs && d_hs_p) begin
               if (d_f1 < 0) d_f1 = k;
               else if (d_f2 < 0) d_f2 = k;
            end
            if (d_hs && !d_hs_p && d_r1 < 0) d_r1 = k;
            if (!s_vs && s_vs_p) begin
               if (s_f1 < 0) s_f1 = k;
               else if (s_f2 < 0) s_f2 = k;
            end
            if (s_vs && !s_vs_p && s_r1 < 0) s_r1 = k;
            if (s_fs) begin
               fs_n++;
               if (fs_k1 < 0) fs_k1 = k;
            end
         end
         d_hs_p = d_hs;
         s_vs_p = s_vs;
      end
   end

   initial begin
      for (int i = 0; i < 19200; i++) mem[i] = 3'($urandom);
      resetn = 1'b0;
      run = 1'b1;
      repeat (4) @(negedge clk);
      resetn = 1'b1;
      // Reset lands part-way through the shrunken frame.
      repeat ($urandom_range(11000, 13000)) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (48000) @(negedge clk);
      check("hs_fall1",  45'(d_f1), 45'(2 * 656 + 2));
      check("hs_period", 45'(d_f2 - d_f1), 45'd1600);
      check("hs_low",    45'(d_r1 - d_f1), 45'd192);
      check("vs_fall1",  45'(s_f1), 45'(2 * (26 * 192 + 1)));
      check("vs_period", 45'(s_f2 - s_f1), 45'(2 * 192 * 61));
      check("vs_low",    45'(s_r1 - s_f1), 45'(2 * 2 * 192));
      check("fs_count",  45'(fs_n), 45'd2);
      check("fs_first",  45'(fs_k1), 45'(2 * 192 * 61));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
